instr_fetch_buffer: RTL and testbench
=====================================

Name: instr_fetch_buffer

Overview:
- Fetch stage directly downstream of the PC register. Each cycle it takes the current Pc, reads instruction memory (synchronous, 1-cycle read latency) and queues {instruction, pc} pairs in a small FIFO for the decode stage.
- Drives the PC register's halt input (fetch_hold) to throttle it when no fetch can be issued.
- Flushes all queued and in-flight fetches on a taken branch or jump.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- CNT_W, 3, width of occupancy count; must equal clog2(DEPTH)+1.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  32  current Pc from PC register (word address).
- flush  in  1  taken branch/jump this cycle; discard everything.
- imem_addr  out  32  instruction memory address.
- imem_rd  out  1  read strobe; data returns next cycle.
- imem_data  in  32  read data, valid the cycle after imem_rd.
- fetch_hold  out  1  to PC halt input; 1 = PC must not advance.
- out_valid  out  1  head entry valid for decode.
- out_ready  in  1  decode accepts head entry.
- out_instr  out  32  head instruction.
- out_pc  out  32  pc of head instruction.
- count  out  CNT_W  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, out_valid=0, inflight=0, rd/wr pointers=0.
  - out_instr=0, out_pc=0.
  - imem_rd=0 and fetch_hold=1 while reset is high.
- Credit rule: issue = !reset && !flush && (count + inflight < DEPTH), where inflight is a 1-bit register.
- Issue cycle:
  - imem_addr = pc_in (combinational); imem_rd = issue.
  - inflight <= issue; inflight_pc <= pc_in.
- Hold signal:
  - fetch_hold = !issue && !flush, so the PC advances exactly once per issued fetch.
  - On flush, hold=0 and the PC's branch/jump path loads the target.
- Return cycle:
  - If inflight=1 and flush=0, write {imem_data, inflight_pc} at wr_ptr.
  - wr_ptr wraps modulo DEPTH.
- Read side:
  - out_valid = (count != 0); out_instr/out_pc come from the rd_ptr entry.
  - Pop when out_valid && out_ready; rd_ptr wraps modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at count=DEPTH only if a pop occurs, but credit never allows a push into a full FIFO without a free slot.
- Latency: pc issued in cycle N → out_valid in cycle N+2 with an empty FIFO.
- Flush (highest priority after reset):
  - Next cycle: count=0, pointers equal, inflight=0.
  - The imem_data returning in the flush cycle is discarded.
  - out_valid is still driven from current state in the flush cycle; a pop in that cycle is honoured.
- Backpressure:
  - With out_ready=0 the FIFO fills to DEPTH (counting the inflight slot).
  - issue then drops and fetch_hold=1 until a pop frees a slot.
  - Issue resumes the cycle after the pop.
- No stored data changes while held; outputs remain stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all queued and in-flight state dropped next edge, identical to a power-on reset.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined:
  - When count=0 and a response returns (inflight=1, flush=0), out_valid=1 in the same cycle, with out_instr=imem_data and out_pc=inflight_pc (combinational bypass).
  - If out_ready=1, the entry is consumed and not written; otherwise it is written normally.
  - Latency N+1.
- Undefined: all data passes through FIFO storage; latency N+2.

Test Plan:
- Reset then out_ready=1, pc_in counting 0,1,2… → imem_rd=1 every cycle; out_pc sequence 0,1,2… starting cycle 2 (cycle 1 with FETCH_BYPASS_EN); out_valid continuous; count<=1.
- out_ready=0 from reset, imem_data=pc+0x100 → count reaches 4, fetch_hold=1, imem_rd=0; one pop → out_pc=0, out_instr=0x100; one issue follows next cycle.
- Flush asserted with count=3 and inflight=1, pc_in=0x40 → count=0 next cycle, the returning word is not enqueued, fetch_hold=0 in the flush cycle; next entry out_pc=0x40 (target issued the cycle after).
- Push and pop in the same cycle at count=2 → count stays 2; pointers wrap after 4 pushes with order preserved (out_pc 0..7 in order).
- Reset asserted with count=2 mid-stream → next cycle out_valid=0, count=0, imem_rd=0, fetch_hold=1; after release, fetch restarts from the current pc_in.
- Flush and out_ready=1 in the same cycle with count=1 → head popped once, FIFO empty after, no duplicate out_pc.

Source files
------------

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: PC, instruction-memory and decode-side signals of the fetch buffer.
interface instr_fetch_buffer_if #(parameter int CNT_W = 3);
   logic [31:0] pc_in, imem_addr, imem_data, out_instr, out_pc;
   logic flush, imem_rd, fetch_hold, out_valid, out_ready;
   logic [CNT_W-1:0] count;
   modport master (
      input  pc_in, flush, imem_data, out_ready,
      output imem_addr, imem_rd, fetch_hold, out_valid, out_instr, out_pc, count
   );
   modport slave (
      output pc_in, flush, imem_data, out_ready,
      input  imem_addr, imem_rd, fetch_hold, out_valid, out_instr, out_pc, count
   );
endinterface

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch stage queueing {instruction, pc} pairs; credit-throttles the PC and flushes on branch.
// FETCH_BYPASS_EN: when defined, a response arriving at an empty FIFO is presented to decode in the same cycle.
module instr_fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input logic clock,
   input logic reset,
   instr_fetch_buffer_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0] mem_instr [DEPTH];
   logic [31:0] mem_pc [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count_q;
   logic inflight;
   logic [31:0] inflight_pc;
   logic issue, byp, fifo_valid, push, pop;
   always_comb begin
      // the in-flight read holds a slot so a returning word always has room
      issue = !reset && !bus.flush && (({1'b0, count_q} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(DEPTH));
      fifo_valid = count_q != '0;
`ifdef FETCH_BYPASS_EN
      byp = !fifo_valid && inflight && !bus.flush;
`else
      byp = 1'b0;
`endif
      pop = fifo_valid && bus.out_ready;
      push = inflight && !bus.flush && !(byp && bus.out_ready);
   end
   assign bus.imem_addr = bus.pc_in;
   assign bus.imem_rd = issue;
   assign bus.fetch_hold = reset || (!issue && !bus.flush);
   assign bus.out_valid = fifo_valid || byp;
   assign bus.out_instr = byp ? bus.imem_data : fifo_valid ? mem_instr[rd_ptr] : '0;
   assign bus.out_pc = byp ? inflight_pc : fifo_valid ? mem_pc[rd_ptr] : '0;
   assign bus.count = count_q;
   always_ff @(posedge clock) begin
      inflight_pc <= bus.pc_in;
      if (reset || bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count_q <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         mem_instr[wr_ptr] <= bus.imem_data;
         mem_pc[wr_ptr] <= inflight_pc;
      end
   end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: randomized bench comparing the fetch buffer against a queue-based model of fetch, PC and decode.
module tb_instr_fetch_buffer;
   localparam int DEPTH = 4;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;
   instr_fetch_buffer_if #(.CNT_W(3)) bus ();
   instr_fetch_buffer #(.DEPTH(DEPTH), .CNT_W(3)) dut (.clock(clock), .reset(reset), .bus(bus));
   logic [63:0] q [$];
   bit infl, post_rst;
   logic [31:0] infl_pc, pc;
   int npass = 0, ntotal = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      ntotal++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      else npass++;
   endtask
   task automatic step(input bit rst, input bit fl, input bit rdy, input logic [31:0] tgt);
      bit iss, hold, byp, vld;
      logic [63:0] head;
      logic [31:0] data;
      int n;
      @(negedge clock);
      data = $urandom;
      reset = rst;
      bus.flush = fl;
      bus.out_ready = rdy;
      bus.pc_in = pc;
      bus.imem_data = data;
      #1;
      n = q.size();
      iss = !rst && !fl && (n + int'(infl) < DEPTH);
      hold = rst || (!iss && !fl);
      byp = 1'b0;
`ifdef FETCH_BYPASS_EN
      byp = (n == 0) && infl && !fl;
`endif
      vld = (n != 0) || byp;
      head = byp ? {data, infl_pc} : (n != 0 ? q[0] : 64'd0);
      check("imem_rd", 64'(bus.imem_rd), 64'(iss));
      check("imem_addr", 64'(bus.imem_addr), 64'(pc));
      check("fetch_hold", 64'(bus.fetch_hold), 64'(hold));
      check("out_valid", 64'(bus.out_valid), 64'(vld));
      check("count", 64'(bus.count), 64'(n));
      if (vld) check("head", {bus.out_instr, bus.out_pc}, head);
      if (post_rst) check("reset_out", {bus.out_instr, bus.out_pc}, 64'd0);
      post_rst = rst;
      if (rst) begin
         q.delete();
         infl = 1'b0;
      end else begin
         if (vld && rdy && !byp) void'(q.pop_front());
         if (infl && !fl && !(byp && rdy)) q.push_back({data, infl_pc});
         if (fl) q.delete();
         infl = iss;
      end
      infl_pc = pc;
      if (!hold) pc = fl ? tgt : pc + 32'd1;
   endtask
   initial begin
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      bus.pc_in = '0;
      bus.imem_data = '0;
      pc = '0;
      infl = 1'b0;
      infl_pc = '0;
      post_rst = 1'b0;
      repeat (2) step(1, 0, 1, 0);
      repeat (12) step(0, 0, 1, 0);
      step(1, 0, 0, 0);
      repeat (8) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0);
      step(0, 1, 0, 32'h40);
      repeat (6) step(0, 0, 1, 0);
      step(1, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0);
      step(0, 1, 1, 32'h80);
      repeat (4) step(0, 0, 1, 0);
      repeat (5) step(0, 0, $urandom_range(0, 1), 0);
      step(1, 0, 0, 0);
      repeat (3) step(0, 0, 1, 0);
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1), $urandom);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
